nv_nvdla_sdp_hls_x_op_rpt: RTL and testbench
============================================

NV_NVDLA_SDP_HLS_X_OP_RPT -- requirements
Module: NV_NVDLA_SDP_HLS_x_op_rpt

Interface
REQ-001 Parameter LANES, default 2, number of 16-bit operand lanes per beat (SDP BN throughput).
REQ-002 Parameter CNT_W, default 13, width of the replay counter and of cfg_repeat.
REQ-003 nvdla_core_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 nvdla_core_rst  in  1  reset, synchronous, active-high.
REQ-005 cfg_repeat  in  CNT_W  presentations per entry minus one, range 1..2^CNT_W presentations per side.
REQ-006 op_in_pvld  in  1  operand entry valid from the DMA unpack stage.
REQ-007 op_in_prdy  out  1  entry accepted when op_in_pvld & op_in_prdy.
REQ-008 op_in_alu  in  16*LANES  per-lane ALU operands, lane i at [16i+15:16i].
REQ-009 op_in_mul  in  16*LANES  per-lane MUL operands, same packing.
REQ-010 chn_alu_op / chn_alu_op_pvld / chn_alu_op_prdy  out/out/in  16*LANES/1/1  ALU operand stream to the X int stage.
REQ-011 chn_mul_op / chn_mul_op_pvld / chn_mul_op_prdy  out/out/in  16*LANES/1/1  MUL operand stream to the X int stage.
REQ-012 rpt_idle  out  1  high when no entry is held.

Function
REQ-013 The block SHALL hold a 2-entry store; each entry = ALU word, MUL word, valid v[e], alu_done[e], mul_done[e].
REQ-014 The block SHALL keep a 1-bit wr_ptr, alu_ptr, mul_ptr and CNT_W-bit counters alu_cnt, mul_cnt.
REQ-015 op_in_prdy SHALL equal !v[wr_ptr], driven from registers only.
REQ-016 On accept the block SHALL write both words into entry wr_ptr, set v[wr_ptr], and toggle wr_ptr.
REQ-017 chn_alu_op_pvld SHALL equal v[alu_ptr] & !alu_done[alu_ptr].
REQ-018 chn_alu_op SHALL equal the ALU word of entry alu_ptr.
REQ-019 chn_mul_op_pvld and chn_mul_op SHALL follow REQ-017/018 using mul_ptr, mul_done and the MUL word.
REQ-020 No combinational path SHALL exist from any input to any output; latency from accept to first pvld = 1 cycle.
REQ-021 Each accepted ALU beat SHALL increment alu_cnt.
REQ-022 On an accepted ALU beat with alu_cnt == cfg_repeat, alu_cnt SHALL go to 0, alu_done[alu_ptr] SHALL set, and alu_ptr SHALL toggle; the MUL side behaves identically and independently.
REQ-023 An entry SHALL be freed (v, alu_done, mul_done cleared) in the same edge in which its second done flag would set.
REQ-024 A freed entry SHALL be writable from the next cycle onward (op_in_prdy rises one cycle after the final beat).
REQ-025 The ALU and MUL sides SHALL advance independently; one side may run up to one full entry ahead of the other, and it stalls (pvld low) while done on its current entry.
REQ-026 Data and pvld SHALL stay stable while pvld & !prdy.
REQ-027 A write to one entry and a free of the other in the same cycle SHALL both take effect.
REQ-028 cfg_repeat == 0 SHALL give exactly one presentation per side per entry; cfg_repeat == 2^CNT_W-1 SHALL give 2^CNT_W presentations without counter wrap error.
REQ-029 cfg_repeat SHALL be held stable by software while rpt_idle is low; changes at other times are undefined.
REQ-030 rpt_idle SHALL equal !(v[0] | v[1]).

Reset
REQ-031 While nvdla_core_rst is high at a clock edge, the block SHALL clear v, done flags, pointers and counters and zero both stored words.
REQ-032 After reset: op_in_prdy=1, both pvld=0, chn_alu_op=chn_mul_op=0, rpt_idle=1.
REQ-033 Reset asserted mid-replay SHALL discard all held entries with no further output beats.

Verification
REQ-034 cfg_repeat=3, one entry ALU=0x0011_0022, MUL=0x0033_0044, both prdy=1 -> exactly 4 beats each of those values on cycles 1-4, rpt_idle=1 on cycle 5.
REQ-035 cfg_repeat=0, back-to-back entries A,B,C, prdy=1 -> output sequence A,B,C with one beat each; op_in_prdy drops only when both entries are held.
REQ-036 cfg_repeat=1, chn_mul_op_prdy=0, chn_alu_op_prdy=1, entries A,B,C offered -> ALU emits A,A,B,B then stalls; op_in_prdy=0; releasing MUL prdy yields MUL A,A,B,B then frees slots and C is accepted.
REQ-037 Random prdy toggling with cfg_repeat=5 -> pvld/data never change while stalled; each side delivers exactly 6 beats per entry, in order.
REQ-038 Reset asserted at the third ALU beat of entry A (cfg_repeat=7) -> the next cycle shows pvld=0, op_in_prdy=1, rpt_idle=1, and no A beats appear afterward.

Source files
------------

// File: rtl/nv_nvdla_sdp_hls_x_op_rpt_if.sv
// Operand handshake bundle: one ALU/MUL entry input stream and two replayed output streams.
// The slave modport is the replay block; the master modport is its environment.
interface nv_nvdla_sdp_hls_x_op_rpt_if #(
    parameter int LANES = 2
);
    logic                  op_in_pvld;
    logic                  op_in_prdy;
    logic [16*LANES-1:0]   op_in_alu;
    logic [16*LANES-1:0]   op_in_mul;
    logic [16*LANES-1:0]   chn_alu_op;
    logic                  chn_alu_op_pvld;
    logic                  chn_alu_op_prdy;
    logic [16*LANES-1:0]   chn_mul_op;
    logic                  chn_mul_op_pvld;
    logic                  chn_mul_op_prdy;

    modport slave (
        input  op_in_pvld, op_in_alu, op_in_mul, chn_alu_op_prdy, chn_mul_op_prdy,
        output op_in_prdy, chn_alu_op, chn_alu_op_pvld, chn_mul_op, chn_mul_op_pvld
    );

    modport master (
        output op_in_pvld, op_in_alu, op_in_mul, chn_alu_op_prdy, chn_mul_op_prdy,
        input  op_in_prdy, chn_alu_op, chn_alu_op_pvld, chn_mul_op, chn_mul_op_pvld
    );
endinterface

// File: rtl/nv_nvdla_sdp_hls_x_op_rpt.sv
// Two-entry operand store that replays each entry cfg_repeat+1 times on independent
// ALU and MUL streams; an entry is released once both sides have finished with it.
module nv_nvdla_sdp_hls_x_op_rpt #(
    parameter int LANES = 2,
    parameter int CNT_W = 13
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic [CNT_W-1:0]     cfg_repeat,
    output logic                 rpt_idle,
    nv_nvdla_sdp_hls_x_op_rpt_if.slave op
);
    localparam int W = 16 * LANES;

    logic [W-1:0]     r_alu_word [2];
    logic [W-1:0]     r_mul_word [2];
    logic [1:0]       r_v;
    logic [1:0]       r_alu_done;
    logic [1:0]       r_mul_done;
    logic             r_wr_ptr;
    logic             r_alu_ptr;
    logic             r_mul_ptr;
    logic [CNT_W-1:0] r_alu_cnt;
    logic [CNT_W-1:0] r_mul_cnt;

    logic             w_accept;
    logic             w_alu_fire;
    logic             w_mul_fire;
    logic             w_alu_last;
    logic             w_mul_last;
    logic [1:0]       w_alu_set;
    logic [1:0]       w_mul_set;
    logic [1:0]       w_free;
    logic [1:0]       w_wr_sel;

    // Every output is a function of registers only.
    assign op.op_in_prdy      = !r_v[r_wr_ptr];
    assign op.chn_alu_op_pvld = r_v[r_alu_ptr] & !r_alu_done[r_alu_ptr];
    assign op.chn_mul_op_pvld = r_v[r_mul_ptr] & !r_mul_done[r_mul_ptr];
    assign op.chn_alu_op      = r_alu_word[r_alu_ptr];
    assign op.chn_mul_op      = r_mul_word[r_mul_ptr];
    assign rpt_idle           = !(r_v[0] | r_v[1]);

    assign w_accept   = op.op_in_pvld & !r_v[r_wr_ptr];
    assign w_alu_fire = op.chn_alu_op_pvld & op.chn_alu_op_prdy;
    assign w_mul_fire = op.chn_mul_op_pvld & op.chn_mul_op_prdy;
    assign w_alu_last = w_alu_fire & (r_alu_cnt == cfg_repeat);
    assign w_mul_last = w_mul_fire & (r_mul_cnt == cfg_repeat);

    always_comb begin
        w_alu_set            = '0;
        w_mul_set            = '0;
        w_wr_sel             = '0;
        w_alu_set[r_alu_ptr] = w_alu_last;
        w_mul_set[r_mul_ptr] = w_mul_last;
        w_wr_sel[r_wr_ptr]   = w_accept;
        // Free on the edge where the second side completes (or both complete together).
        w_free = r_v & (r_alu_done | w_alu_set) & (r_mul_done | w_mul_set)
                     & (w_alu_set | w_mul_set);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_alu_word[0] <= '0;
            r_alu_word[1] <= '0;
            r_mul_word[0] <= '0;
            r_mul_word[1] <= '0;
            r_v           <= '0;
            r_alu_done    <= '0;
            r_mul_done    <= '0;
            r_wr_ptr      <= 1'b0;
            r_alu_ptr     <= 1'b0;
            r_mul_ptr     <= 1'b0;
            r_alu_cnt     <= '0;
            r_mul_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_alu_word[r_wr_ptr] <= op.op_in_alu;
                r_mul_word[r_wr_ptr] <= op.op_in_mul;
                r_wr_ptr             <= !r_wr_ptr;
            end
            // A write only targets an empty slot, a free only a held one, so both may land together.
            r_v        <= (r_v & ~w_free) | w_wr_sel;
            r_alu_done <= (r_alu_done | w_alu_set) & ~w_free;
            r_mul_done <= (r_mul_done | w_mul_set) & ~w_free;

            if (w_alu_fire) begin
                if (w_alu_last) begin
                    r_alu_cnt <= '0;
                    r_alu_ptr <= !r_alu_ptr;
                end else begin
                    r_alu_cnt <= r_alu_cnt + 1'b1;
                end
            end
            if (w_mul_fire) begin
                if (w_mul_last) begin
                    r_mul_cnt <= '0;
                    r_mul_ptr <= !r_mul_ptr;
                end else begin
                    r_mul_cnt <= r_mul_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_nv_nvdla_sdp_hls_x_op_rpt.sv
// Bench for the operand replay block: an entry-level model (accepted list plus per-side
// completed-entry counts) checked every cycle, with directed and random scenarios.
module tb_nv_nvdla_sdp_hls_x_op_rpt;
    localparam int LANES = 2;
    localparam int CNT_W = 13;
    localparam int W     = 16 * LANES;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] cfg;
    logic             idle;

    nv_nvdla_sdp_hls_x_op_rpt_if #(.LANES(LANES)) op_if ();

    nv_nvdla_sdp_hls_x_op_rpt #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_repeat     (cfg),
        .rpt_idle       (idle),
        .op             (op_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_seq(input string nm, input logic [W-1:0] got[$], input logic [W-1:0] exp[$]);
        chk({nm, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk(nm, 64'(got[i]), 64'(exp[i]));
    endtask

    // Model: entries accepted so far, and how many entries each side has fully replayed.
    logic [W-1:0] m_alu_q[$];
    logic [W-1:0] m_mul_q[$];
    int  n_acc, a_ent, a_beat, m_ent, m_beat, held;
    bit  model_on = 0;
    bit  e_apv, e_mpv, e_acc;

    logic [W-1:0] alu_seen[$];
    logic [W-1:0] mul_seen[$];

    always @(negedge clk) begin
        held = n_acc - ((a_ent < m_ent) ? a_ent : m_ent);
        e_apv = (a_ent < n_acc);
        e_mpv = (m_ent < n_acc);
        if (model_on) begin
            chk("op_in_prdy", op_if.op_in_prdy, held < 2);
            chk("rpt_idle", idle, held == 0);
            chk("alu_pvld", op_if.chn_alu_op_pvld, e_apv);
            chk("mul_pvld", op_if.chn_mul_op_pvld, e_mpv);
            if (e_apv) chk("alu_data", op_if.chn_alu_op, m_alu_q[a_ent]);
            if (e_mpv) chk("mul_data", op_if.chn_mul_op, m_mul_q[m_ent]);
            if (op_if.chn_alu_op_pvld && op_if.chn_alu_op_prdy) alu_seen.push_back(op_if.chn_alu_op);
            if (op_if.chn_mul_op_pvld && op_if.chn_mul_op_prdy) mul_seen.push_back(op_if.chn_mul_op);
        end
        if (rst) begin
            m_alu_q.delete();
            m_mul_q.delete();
            n_acc = 0; a_ent = 0; a_beat = 0; m_ent = 0; m_beat = 0;
            model_on = 1;
        end else if (model_on) begin
            e_acc = op_if.op_in_pvld && (held < 2);
            if (e_apv && op_if.chn_alu_op_prdy) begin
                a_beat++;
                if (a_beat == int'(cfg) + 1) begin a_ent++; a_beat = 0; end
            end
            if (e_mpv && op_if.chn_mul_op_prdy) begin
                m_beat++;
                if (m_beat == int'(cfg) + 1) begin m_ent++; m_beat = 0; end
            end
            if (e_acc) begin
                m_alu_q.push_back(op_if.op_in_alu);
                m_mul_q.push_back(op_if.op_in_mul);
                n_acc++;
            end
        end
    end

    // Stimulus: entries waiting to be offered on the input stream.
    logic [W-1:0] sa_q[$];
    logic [W-1:0] sm_q[$];
    bit rnd_prdy = 0;

    task automatic apply();
        op_if.op_in_pvld = (sa_q.size() > 0);
        op_if.op_in_alu  = (sa_q.size() > 0) ? sa_q[0] : '0;
        op_if.op_in_mul  = (sm_q.size() > 0) ? sm_q[0] : '0;
        if (rnd_prdy) begin
            op_if.chn_alu_op_prdy = 1'($urandom_range(0, 1));
            op_if.chn_mul_op_prdy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic tick();
        bit acc;
        @(negedge clk);
        acc = op_if.op_in_pvld && op_if.op_in_prdy && !rst;
        @(posedge clk);
        #1;
        if (acc) begin
            void'(sa_q.pop_front());
            void'(sm_q.pop_front());
        end
        apply();
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] m);
        sa_q.push_back(a);
        sm_q.push_back(m);
    endtask

    logic [W-1:0] ex_a[$];
    logic [W-1:0] ex_m[$];
    logic [W-1:0] ra[$];
    logic [W-1:0] rm[$];

    initial begin
        rst = 1'b1;
        cfg = '0;
        op_if.op_in_pvld = 1'b0;
        op_if.op_in_alu = '0;
        op_if.op_in_mul = '0;
        op_if.chn_alu_op_prdy = 1'b1;
        op_if.chn_mul_op_prdy = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_prdy", op_if.op_in_prdy, 1'b1);
        chk("rst_alu_pvld", op_if.chn_alu_op_pvld, 1'b0);
        chk("rst_mul_pvld", op_if.chn_mul_op_pvld, 1'b0);
        chk("rst_alu_op", op_if.chn_alu_op, 0);
        chk("rst_mul_op", op_if.chn_mul_op, 0);
        chk("rst_idle", idle, 1'b1);

        // One entry, four presentations each side.
        cfg = 13'd3;
        push(32'h0011_0022, 32'h0033_0044);
        apply();
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("r3_alu_pvld", op_if.chn_alu_op_pvld, 1'b1);
            chk("r3_alu_op", op_if.chn_alu_op, 32'h0011_0022);
            chk("r3_mul_pvld", op_if.chn_mul_op_pvld, 1'b1);
            chk("r3_mul_op", op_if.chn_mul_op, 32'h0033_0044);
            tick();
        end
        chk("r3_idle", idle, 1'b1);
        chk("r3_alu_pvld_end", op_if.chn_alu_op_pvld, 1'b0);
        chk("r3_mul_pvld_end", op_if.chn_mul_op_pvld, 1'b0);

        // Back-to-back single presentations.
        cfg = '0;
        alu_seen.delete(); mul_seen.delete();
        push(32'hA0A0_0001, 32'hB0B0_0001);
        push(32'hA0A0_0002, 32'hB0B0_0002);
        push(32'hA0A0_0003, 32'hB0B0_0003);
        apply();
        for (int k = 0; k < 8; k++) tick();
        ex_a = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
        ex_m = '{32'hB0B0_0001, 32'hB0B0_0002, 32'hB0B0_0003};
        chk_seq("b2b_alu", alu_seen, ex_a);
        chk_seq("b2b_mul", mul_seen, ex_m);

        // MUL side blocked: ALU runs one entry ahead, then the store fills.
        cfg = 13'd1;
        alu_seen.delete(); mul_seen.delete();
        op_if.chn_mul_op_prdy = 1'b0;
        push(32'h0000_00AA, 32'h0000_00DA);
        push(32'h0000_00BB, 32'h0000_00DB);
        push(32'h0000_00CC, 32'h0000_00DC);
        apply();
        for (int k = 0; k < 10; k++) tick();
        ex_a = '{32'hAA, 32'hAA, 32'hBB, 32'hBB};
        ex_m = {};
        chk_seq("stall_alu", alu_seen, ex_a);
        chk_seq("stall_mul", mul_seen, ex_m);
        chk("stall_prdy", op_if.op_in_prdy, 1'b0);
        chk("stall_c_pending", 64'(sa_q.size()), 1);
        op_if.chn_mul_op_prdy = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        ex_a = '{32'hAA, 32'hAA, 32'hBB, 32'hBB, 32'hCC, 32'hCC};
        ex_m = '{32'hDA, 32'hDA, 32'hDB, 32'hDB, 32'hDC, 32'hDC};
        chk_seq("rel_alu", alu_seen, ex_a);
        chk_seq("rel_mul", mul_seen, ex_m);
        chk("rel_c_taken", 64'(sa_q.size()), 0);

        // Random backpressure, six presentations per entry.
        cfg = 13'd5;
        alu_seen.delete(); mul_seen.delete();
        ex_a.delete(); ex_m.delete();
        for (int i = 0; i < 20; i++) begin
            ra.push_back(W'($urandom));
            rm.push_back(W'($urandom));
            push(ra[i], rm[i]);
            for (int j = 0; j < 6; j++) begin
                ex_a.push_back(ra[i]);
                ex_m.push_back(rm[i]);
            end
        end
        rnd_prdy = 1;
        apply();
        begin
            int budget;
            budget = 0;
            while (budget < 3000 && !(sa_q.size() == 0 && idle)) begin
                tick();
                budget++;
            end
            chk("rand_drained", 64'(budget < 3000), 1);
        end
        rnd_prdy = 0;
        op_if.chn_alu_op_prdy = 1'b1;
        op_if.chn_mul_op_prdy = 1'b1;
        tick();
        chk_seq("rand_alu", alu_seen, ex_a);
        chk_seq("rand_mul", mul_seen, ex_m);

        // Reset in the middle of a replay.
        cfg = 13'd7;
        push(32'h1234_5678, 32'h9ABC_DEF0);
        apply();
        tick(); tick(); tick();
        chk("mid_alu_pvld", op_if.chn_alu_op_pvld, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_pvld", op_if.chn_alu_op_pvld, 1'b0);
        chk("mid_rst_prdy", op_if.op_in_prdy, 1'b1);
        chk("mid_rst_idle", idle, 1'b1);
        alu_seen.delete(); mul_seen.delete();
        for (int k = 0; k < 12; k++) tick();
        chk("mid_rst_no_beats", 64'(alu_seen.size() + mul_seen.size()), 0);

        // Largest repeat count: full counter range without wrap.
        cfg = '1;
        push(32'h5555_AAAA, 32'h0F0F_F0F0);
        apply();
        for (int k = 0; k < 8200; k++) tick();
        chk("max_alu_beats", 64'(alu_seen.size()), 8192);
        chk("max_mul_beats", 64'(mul_seen.size()), 8192);
        chk("max_idle", idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
